// File: rtl/sram_packet_master.sv
// Host-side initiator for the SRAM packet protocol: one command in flight,
// builds the request packet and returns exactly one completion per command.
module sram_packet_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PACKET_WIDTH   = 8 + ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned WRITE_LAT      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    packet_valid,
  input  logic [PACKET_WIDTH-1:0] resp_packet,
  input  logic                    resp_valid,
  output logic                    rsp_valid,
  output logic                    rsp_write,
  output logic [ADDR_WIDTH-1:0]   rsp_addr,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_timeout,
  output logic [7:0]              stray_cnt
);

  localparam int unsigned MAX_WAIT = (WRITE_LAT > TIMEOUT_CYCLES) ? WRITE_LAT : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [7:0]  HDR_RD   = 8'hAA;
  localparam logic [7:0]  HDR_WR   = 8'hBB;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    cmd_ready_d, packet_valid_d, rsp_valid_d;
  logic                    rsp_write_d, rsp_timeout_d;
  logic [PACKET_WIDTH-1:0] packet_out_d;
  logic [ADDR_WIDTH-1:0]   rsp_addr_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic [7:0]              stray_cnt_d;
  logic                    resp_hit;

  // The response address field carries no information for the master.
  logic resp_addr_unused;
  assign resp_addr_unused = ^resp_packet[PACKET_WIDTH-9:DATA_WIDTH];

  assign resp_hit = (state_q == RD_WAIT) && resp_valid &&
                    (resp_packet[PACKET_WIDTH-1 -: 8] == HDR_RD);

  // Next-state and next-output logic; cnt_q holds the number of the upcoming edge.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    cmd_ready_d    = cmd_ready;
    packet_out_d   = packet_out;
    packet_valid_d = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_write_d    = rsp_write;
    rsp_addr_d     = rsp_addr;
    rsp_rdata_d    = rsp_rdata;
    rsp_timeout_d  = rsp_timeout;
    stray_cnt_d    = stray_cnt;

    if (resp_valid && !resp_hit && (stray_cnt != 8'hFF)) begin
      stray_cnt_d = stray_cnt + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d         = cmd_addr;
          packet_valid_d = 1'b1;
          cmd_ready_d    = 1'b0;
          cnt_d          = CNT_W'(1);
          if (cmd_write) begin
            packet_out_d = PACKET_WIDTH'({HDR_WR, cmd_addr, cmd_wdata});
            state_d      = WR_WAIT;
          end else begin
            packet_out_d = PACKET_WIDTH'({HDR_RD, cmd_addr, {DATA_WIDTH{1'b0}}});
            state_d      = RD_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (cnt_q == CNT_W'(WRITE_LAT)) begin
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_addr_d    = addr_q;
          rsp_rdata_d   = '0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_WAIT: begin
        // A response on the expiry edge still wins over the timeout.
        if (resp_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_addr_d    = addr_q;
          rsp_rdata_d   = resp_packet[DATA_WIDTH-1:0];
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_addr_d    = addr_q;
          rsp_rdata_d   = '0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      cmd_ready    <= 1'b1;
      packet_out   <= '0;
      packet_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_addr     <= '0;
      rsp_rdata    <= '0;
      rsp_timeout  <= 1'b0;
      stray_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      cmd_ready    <= cmd_ready_d;
      packet_out   <= packet_out_d;
      packet_valid <= packet_valid_d;
      rsp_valid    <= rsp_valid_d;
      rsp_write    <= rsp_write_d;
      rsp_addr     <= rsp_addr_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_timeout  <= rsp_timeout_d;
      stray_cnt    <= stray_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_packet_master.sv
// Bench for sram_packet_master: vector table plus scoreboard of expected completions.
module tb_sram_packet_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [47:0] packet_out;
  logic        packet_valid;
  logic [47:0] resp_packet = '0;
  logic        resp_valid = 1'b0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [7:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [7:0]  stray_cnt;

  sram_packet_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .packet_out(packet_out), .packet_valid(packet_valid),
    .resp_packet(resp_packet), .resp_valid(resp_valid),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          resp_cyc;   // cycle of resp_valid after accept, 0 = none
    logic [7:0]  resp_hdr;
    logic [31:0] resp_data;
    logic [47:0] exp_pkt;
    int          exp_lat;
    bit          exp_to;
    logic [31:0] exp_rdata;
    int          stray_inc;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] rdata;
    bit          to;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   exp_stray = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [7:0] addr, logic [31:0] wdata, int rc,
                              logic [7:0] hdr, logic [31:0] rd, logic [47:0] pkt,
                              int lat, bit to, logic [31:0] erd, int si);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.resp_cyc = rc; v.resp_hdr = hdr;
    v.resp_data = rd; v.exp_pkt = pkt; v.exp_lat = lat; v.exp_to = to;
    v.exp_rdata = erd; v.stray_inc = si;
    return v;
  endfunction

  function automatic int sat(int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Completion monitor: every rsp_valid pops and is compared with the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_write", rsp_write, e.wr);
        check("rsp_addr", rsp_addr, e.addr);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_timeout", rsp_timeout, e.to);
        check("rsp_latency", cyc - e.acc, e.lat);
        check("cmd_ready_at_rsp", cmd_ready, 1);
        n_done++;
      end
    end
  end

  task automatic push_exp(bit wr, logic [7:0] addr, logic [31:0] rd, bit to, int acc, int lat);
    exp_t e;
    e.wr = wr; e.addr = addr; e.rdata = rd; e.to = to; e.acc = acc; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
  endtask

  task automatic run_cmd(input vec_t v);
    int acc, last, done0;
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    acc = cyc + 1;
    done0 = n_done;
    exp_stray = sat(exp_stray + v.stray_inc);
    push_exp(v.wr, v.addr, v.exp_rdata, v.exp_to, acc, v.exp_lat);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = 32'h0;
    check("packet_valid_c0", packet_valid, 1);
    check("packet_out", packet_out, v.exp_pkt);
    check("cmd_ready_c0", cmd_ready, 0);
    last = ((v.exp_lat > v.resp_cyc) ? v.exp_lat : v.resp_cyc) + 1;
    resp_packet = {v.resp_hdr, 8'h5A, v.resp_data};
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check("packet_hold", {packet_valid, packet_out}, {1'b0, v.exp_pkt});
      resp_valid = (k == v.resp_cyc);
    end
    resp_valid = 1'b0;
    check("completions", n_done - done0, 1);
    check("stray_cnt", stray_cnt, exp_stray);
  endtask

  initial begin
    logic [47:0] wpkt, rpkt;
    int acc, done0;

    vecs[0] = mk(1, 8'h12, 32'hDEADBEEF, 0,  8'h00, 32'h0, 48'hBB12DEADBEEF, 3,  0, 32'h0, 0);
    vecs[1] = mk(0, 8'h12, 32'h0,        2,  8'hAA, 32'hDEADBEEF, 48'hAA1200000000, 3, 0, 32'hDEADBEEF, 0);
    vecs[2] = mk(0, 8'h34, 32'hFFFFFFFF, 0,  8'h00, 32'h0, 48'hAA3400000000, 16, 1, 32'h0, 0);
    vecs[3] = mk(0, 8'h56, 32'h0,        15, 8'hAA, 32'h12345678, 48'hAA5600000000, 16, 0, 32'h12345678, 0);
    vecs[4] = mk(0, 8'h78, 32'h0,        16, 8'hAA, 32'h87654321, 48'hAA7800000000, 16, 1, 32'h0, 1);
    vecs[5] = mk(1, 8'hFF, 32'h00000000, 0,  8'h00, 32'h0, 48'hBBFF00000000, 3,  0, 32'h0, 0);
    vecs[6] = mk(0, 8'h00, 32'h0,        5,  8'hBB, 32'h11111111, 48'hAA0000000000, 16, 1, 32'h0, 1);
    vecs[7] = mk(0, 8'h9A, 32'h0,        7,  8'hAA, 32'hCAFEF00D, 48'hAA9A00000000, 8,  0, 32'hCAFEF00D, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_packet", {packet_valid, packet_out}, 0);
    check("reset_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_addr, rsp_rdata}, 0);
    check("reset_stray", stray_cnt, 0);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Back-to-back write then read with cmd_valid held high.
    @(negedge clk);
    wait_ready();
    wpkt = 48'hBB1100001111;
    rpkt = 48'hAA2200000000;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h11; cmd_wdata = 32'h00001111;
    acc = cyc + 1;
    done0 = n_done;
    push_exp(1, 8'h11, 32'h0, 0, acc, 3);
    push_exp(0, 8'h22, 32'h0BADF00D, 0, acc + 4, 3);
    resp_packet = {8'hAA, 8'h00, 32'h0BADF00D};
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("b2b_packet_valid", packet_valid, (k == 0 || k == 4));
      check("b2b_packet_out", packet_out, (k < 4) ? wpkt : rpkt);
      if (k == 0) begin cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 32'h55555555; end
      if (k == 4) cmd_valid = 1'b0;
      resp_valid = (k == 6);
    end
    resp_valid = 1'b0;
    check("b2b_completions", n_done - done0, 2);

    // Stray responses while idle saturate the counter.
    resp_packet = {8'hAA, 8'h00, 32'h1};
    for (int k = 0; k < 300; k++) begin
      resp_valid = 1'b1;
      @(negedge clk);
    end
    resp_valid = 1'b0;
    exp_stray = 255;
    @(negedge clk);
    check("stray_saturated", stray_cnt, exp_stray);

    // Reset in cycle 1 of a read drops the command.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst_seq_accept", packet_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_packet", {packet_valid, packet_out}, 0);
    check("rst_mid_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_addr, rsp_rdata}, 0);
    check("rst_mid_stray", stray_cnt, 0);
    resp_packet = {8'hAA, 8'h44, 32'hFEEDFACE};
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    exp_stray = 1;
    @(negedge clk);
    check("late_resp_stray", stray_cnt, exp_stray);
    repeat (20) @(negedge clk);
    check("no_pending_rsp", sb.size(), 0);

    run_cmd(vecs[0]);
    run_cmd(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
